// File: rtl/scoreboard_pkg.sv
// Shared types for the register-write scoreboard: address/count typedefs and the issue bundle.
// No logic; latency n/a; backpressure n/a.
// Default counter width covers SB_MAX_INFLIGHT outstanding writes per register.
package scoreboard_pkg;

    localparam int SB_NREG         = 32;
    localparam int CREG_W          = 5;
    localparam int SB_MAX_INFLIGHT = 3;
    localparam int SB_CNT_W        = $clog2(SB_MAX_INFLIGHT + 1);

    typedef logic [CREG_W-1:0]   creg_addr_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t srca;
        creg_addr_t srcb;
        logic       use_a;
        logic       use_b;
        creg_addr_t dst;
        logic       dst_valid;
        logic       slow;
    } sb_issue_t;

endpackage

// File: rtl/scoreboard_if.sv
// Issue/ready/writeback bundle between the pipeline stages and the scoreboard.
// Wires only; latency n/a; backpressure is the stall signal back to ID.
// master = pipeline side, slave = scoreboard side.
interface scoreboard_if;
    import scoreboard_pkg::*;

    logic       id_valid;
    creg_addr_t id_srca;
    creg_addr_t id_srcb;
    logic       id_use_a;
    logic       id_use_b;
    creg_addr_t id_dst;
    logic       id_dst_valid;
    logic       id_slow;
    logic       rdy_valid;
    creg_addr_t rdy_dst;
    logic       wb_valid;
    creg_addr_t wb_dst;
    logic       flush;
    logic       stall;
    logic       issue_fire;
    logic       busy;

    modport master (
        output id_valid, id_srca, id_srcb, id_use_a, id_use_b,
        output id_dst, id_dst_valid, id_slow,
        output rdy_valid, rdy_dst, wb_valid, wb_dst, flush,
        input  stall, issue_fire, busy
    );

    modport slave (
        input  id_valid, id_srca, id_srcb, id_use_a, id_use_b,
        input  id_dst, id_dst_valid, id_slow,
        input  rdy_valid, rdy_dst, wb_valid, wb_dst, flush,
        output stall, issue_fire, busy
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One architectural register's outstanding-write and outstanding-slow-write counters.
// Flags are registered state, visible the cycle after an event.
// No backpressure; the parent never increments a full entry.
module sb_entry
    import scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic inc,
    input  logic slow,
    input  logic rdy,
    input  logic wb,
    output logic is_wait,
    output logic is_full,
    output logic is_busy
);

    sb_cnt_t cnt, cnt_nxt;
    sb_cnt_t slow_cnt, slow_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        slow_nxt = slow_cnt;
        if (inc && !wb)
            cnt_nxt = cnt + sb_cnt_t'(1);
        else if (!inc && wb && cnt != '0)
            cnt_nxt = cnt - sb_cnt_t'(1);
        if (inc && slow && !rdy)
            slow_nxt = slow_cnt + sb_cnt_t'(1);
        else if (!(inc && slow) && rdy && slow_cnt != '0)
            slow_nxt = slow_cnt - sb_cnt_t'(1);
        if (flush) begin
            cnt_nxt  = '0;
            slow_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            slow_cnt <= '0;
        end else begin
            cnt      <= cnt_nxt;
            slow_cnt <= slow_nxt;
        end
    end

    assign is_wait = (slow_cnt != '0);
    assign is_full = (cnt == sb_cnt_t'(MAX_INFLIGHT));
    assign is_busy = (cnt != '0);

    // Events arrive in program order, so a decrement on an empty counter is a pipeline bug.
    wb_underflow:  assert property (@(posedge clk) disable iff (!reset || flush) !(wb && cnt == '0));
    rdy_underflow: assert property (@(posedge clk) disable iff (!reset || flush) !(rdy && slow_cnt == '0));

endmodule

// File: rtl/scoreboard.sv
// Per-register in-flight write tracker; stalls ID on slow-source or too-many-writes hazards.
// stall/issue_fire are combinational from registered state; table updates land next cycle.
// Backpressure: stall holds ID; SCOREBOARD_PERF_EN adds stall_cycles/waw_stalls counters.
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NREG         = SB_NREG,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        reset,
    scoreboard_if.slave sb
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [63:0] stall_cycles,
    output logic [31:0] waw_stalls
`endif
);

    sb_issue_t iss;
    assign iss = '{valid:     sb.id_valid,
                   srca:      sb.id_srca,
                   srcb:      sb.id_srcb,
                   use_a:     sb.id_use_a,
                   use_b:     sb.id_use_b,
                   dst:       sb.id_dst,
                   dst_valid: sb.id_dst_valid,
                   slow:      sb.id_slow};

    logic [NREG-1:0] wait_vec, full_vec, busy_vec;
    logic haz_a, haz_b, haz_waw, stall_i, fire_i;

    // x0 is hardwired: no entry, never waits, never full.
    assign wait_vec[0] = 1'b0;
    assign full_vec[0] = 1'b0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .flush   (sb.flush),
            .inc     (fire_i && iss.dst_valid && iss.dst == creg_addr_t'(r)),
            .slow    (iss.slow),
            .rdy     (sb.rdy_valid && sb.rdy_dst == creg_addr_t'(r)),
            .wb      (sb.wb_valid && sb.wb_dst == creg_addr_t'(r)),
            .is_wait (wait_vec[r]),
            .is_full (full_vec[r]),
            .is_busy (busy_vec[r])
        );
    end

    assign haz_a   = iss.use_a && iss.srca != '0 && wait_vec[iss.srca];
    assign haz_b   = iss.use_b && iss.srcb != '0 && wait_vec[iss.srcb];
    assign haz_waw = iss.dst_valid && iss.dst != '0 && full_vec[iss.dst];
    assign stall_i = iss.valid && (haz_a || haz_b || haz_waw);
    assign fire_i  = iss.valid && !stall_i;

    assign sb.stall      = stall_i;
    assign sb.issue_fire = fire_i;
    assign sb.busy       = |busy_vec;

`ifdef SCOREBOARD_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            waw_stalls   <= '0;
        end else begin
            if (stall_i)
                stall_cycles <= stall_cycles + 64'd1;
            if (stall_i && haz_waw && !haz_a && !haz_b)
                waw_stalls <= waw_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Directed vectors for the scoreboard; a driver queues expected {stall, issue_fire, busy}
// per cycle and an independent monitor checks them at the falling edge.
module tb_scoreboard;
    import scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scoreboard_if sbi();

`ifdef SCOREBOARD_PERF_EN
    logic [63:0] stall_cycles;
    logic [31:0] waw_stalls;
    scoreboard dut (.clk(clk), .reset(rst_n), .sb(sbi),
                    .stall_cycles(stall_cycles), .waw_stalls(waw_stalls));
`else
    scoreboard dut (.clk(clk), .reset(rst_n), .sb(sbi));
`endif

    typedef struct {
        string      nm;
        logic [2:0] exp;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    longint exp_stall_cyc = 0;
    int     exp_waw       = 0;

    // Staged inputs for the next cycle; cleared after each tick.
    bit st_rst, st_v, st_ua, st_ub, st_dv, st_sl, st_rv, st_wv, st_fl;
    int st_sa, st_sb, st_d, st_rd, st_wd;

    task automatic clear_stage();
        st_rst = 1'b1; st_v = 0; st_ua = 0; st_ub = 0; st_dv = 0; st_sl = 0;
        st_rv = 0; st_wv = 0; st_fl = 0;
        st_sa = 0; st_sb = 0; st_d = 0; st_rd = 0; st_wd = 0;
    endtask

    task automatic set_id(input int sa, input bit ua, input int sb_, input bit ub,
                          input int d, input bit dv, input bit sl);
        st_v = 1; st_sa = sa; st_ua = ua; st_sb = sb_; st_ub = ub;
        st_d = d; st_dv = dv; st_sl = sl;
    endtask

    task automatic set_rdy(input int r); st_rv = 1; st_rd = r; endtask
    task automatic set_wb(input int r);  st_wv = 1; st_wd = r; endtask

    // Apply staged inputs for one cycle and queue the expected outputs for it.
    task automatic tick(input string nm, input bit s, input bit f, input bit b, input bit waw = 0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = st_rst;
        sbi.id_valid     = st_v;
        sbi.id_srca      = creg_addr_t'(st_sa);
        sbi.id_use_a     = st_ua;
        sbi.id_srcb      = creg_addr_t'(st_sb);
        sbi.id_use_b     = st_ub;
        sbi.id_dst       = creg_addr_t'(st_d);
        sbi.id_dst_valid = st_dv;
        sbi.id_slow      = st_sl;
        sbi.rdy_valid    = st_rv;
        sbi.rdy_dst      = creg_addr_t'(st_rd);
        sbi.wb_valid     = st_wv;
        sbi.wb_dst       = creg_addr_t'(st_wd);
        sbi.flush        = st_fl;
        if (!st_rst) begin
            exp_stall_cyc = 0;
            exp_waw       = 0;
        end else begin
            if (s)   exp_stall_cyc++;
            if (waw) exp_waw++;
        end
        e.nm  = nm;
        e.exp = {s, f, b};
        q.push_back(e);
        clear_stage();
    endtask

    // Monitor: checks every queued expectation against the live outputs.
    initial begin
        exp_t e;
        logic [2:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {sbi.stall, sbi.issue_fire, sbi.busy};
                total++;
                if (got !== e.exp) begin
                    bad++;
                    $display("FAIL %s {stall,fire,busy} got=%b want=%b", e.nm, got, e.exp);
                end
            end
        end
    end

    initial begin
        clear_stage();
        sbi.id_valid = 0; sbi.id_srca = '0; sbi.id_use_a = 0; sbi.id_srcb = '0;
        sbi.id_use_b = 0; sbi.id_dst = '0; sbi.id_dst_valid = 0; sbi.id_slow = 0;
        sbi.rdy_valid = 0; sbi.rdy_dst = '0; sbi.wb_valid = 0; sbi.wb_dst = '0;
        sbi.flush = 0;

        // Reset state
        st_rst = 0; tick("rst0", 0, 0, 0);
        st_rst = 0; tick("rst1", 0, 0, 0);
        tick("post_rst", 0, 0, 0);

        // Synchronous reset mid-flight drops all tracking, including a same-cycle issue
        set_id(0, 0, 0, 0, 11, 1, 1); tick("mr_ld11", 0, 1, 0);
        set_id(0, 0, 0, 0, 12, 1, 0); tick("mr_wr12", 0, 1, 1);
        st_rst = 0; set_id(0, 0, 0, 0, 13, 1, 0); tick("mr_rst", 0, 1, 1);
        set_id(11, 1, 0, 0, 0, 0, 0); tick("mr_rd11", 0, 1, 0);
        tick("mr_idle", 0, 0, 0);

        // Load-use: rdy in cycle 3 releases the reader in cycle 4
        set_id(0, 0, 0, 0, 5, 1, 1); tick("lu_ld5", 0, 1, 0);
        set_id(5, 1, 0, 0, 0, 0, 0); tick("lu_c1", 1, 0, 1);
        set_id(5, 1, 0, 0, 0, 0, 0); tick("lu_c2", 1, 0, 1);
        set_id(5, 1, 0, 0, 0, 0, 0); set_rdy(5); tick("lu_c3_rdy", 1, 0, 1);
        set_id(5, 1, 0, 0, 0, 0, 0); tick("lu_c4", 0, 1, 1);
        set_wb(5); tick("lu_wb", 0, 0, 1);
        tick("lu_idle", 0, 0, 0);

        // ALU back-to-back: no stall, two writes outstanding need two wbs
        set_id(0, 0, 0, 0, 6, 1, 0); tick("alu_add", 0, 1, 0);
        set_id(6, 1, 0, 0, 6, 1, 0); tick("alu_sub", 0, 1, 1);
        set_wb(6); tick("alu_wb1", 0, 0, 1);
        set_wb(6); tick("alu_wb2", 0, 0, 1);
        tick("alu_idle", 0, 0, 0);

        // WAW limit: fourth write stalls, also during the wb cycle
        set_id(0, 0, 0, 0, 7, 1, 0); tick("waw_w1", 0, 1, 0);
        set_id(0, 0, 0, 0, 7, 1, 0); tick("waw_w2", 0, 1, 1);
        set_id(0, 0, 0, 0, 7, 1, 0); tick("waw_w3", 0, 1, 1);
        set_id(0, 0, 0, 0, 7, 1, 0); tick("waw_w4", 1, 0, 1, 1);
        set_id(0, 0, 0, 0, 7, 1, 0); set_wb(7); tick("waw_w4_wb", 1, 0, 1, 1);
        set_id(0, 0, 0, 0, 7, 1, 0); tick("waw_w4_go", 0, 1, 1);
        set_wb(7); tick("waw_d1", 0, 0, 1);
        set_wb(7); tick("waw_d2", 0, 0, 1);
        set_wb(7); tick("waw_d3", 0, 0, 1);
        tick("waw_idle", 0, 0, 0);

        // Two loads to x8: reader waits for both rdy events
        set_id(0, 0, 0, 0, 8, 1, 1); tick("l2_ld1", 0, 1, 0);
        set_id(0, 0, 0, 0, 8, 1, 1); tick("l2_ld2", 0, 1, 1);
        set_id(0, 0, 8, 1, 0, 0, 0); tick("l2_rd", 1, 0, 1);
        set_id(0, 0, 8, 1, 0, 0, 0); set_rdy(8); tick("l2_rdy1", 1, 0, 1);
        set_id(0, 0, 8, 1, 0, 0, 0); set_rdy(8); tick("l2_rdy2", 1, 0, 1);
        set_id(0, 0, 8, 1, 0, 0, 0); tick("l2_go", 0, 1, 1);
        set_wb(8); tick("l2_wb1", 0, 0, 1);
        set_wb(8); tick("l2_wb2", 0, 0, 1);
        tick("l2_idle", 0, 0, 0);

        // x0 is never tracked
        set_id(0, 0, 0, 0, 0, 1, 1); tick("x0_ld", 0, 1, 0);
        set_id(0, 1, 0, 1, 0, 0, 0); tick("x0_rd", 0, 1, 0);
        set_rdy(0); set_wb(0); tick("x0_ev", 0, 0, 0);
        tick("x0_idle", 0, 0, 0);

        // Flush discards the table and a same-cycle issue
        set_id(0, 0, 0, 0, 9, 1, 1); tick("fl_ld9", 0, 1, 0);
        set_id(0, 0, 0, 0, 10, 1, 1); st_fl = 1; tick("fl_flush", 0, 1, 1);
        set_id(9, 1, 10, 1, 0, 0, 0); tick("fl_rd", 0, 1, 0);
        tick("fl_idle", 0, 0, 0);

        @(negedge clk);
        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d want=0", q.size());
        end
`ifdef SCOREBOARD_PERF_EN
        total++;
        if (stall_cycles !== 64'(exp_stall_cyc)) begin
            bad++;
            $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, exp_stall_cyc);
        end
        total++;
        if (waw_stalls !== 32'(exp_waw)) begin
            bad++;
            $display("FAIL waw_stalls got=%0d want=%0d", waw_stalls, exp_waw);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
